// File: rtl/bp_me_stream_pump_arb_if.sv
// Bundle of requester-side and pump-side signals around the stream pump arbiter.
// The arbiter takes the slave view; requesters and the pump share the master view.
interface bp_me_stream_pump_arb_if #(
  parameter int num_req_p      = 4,
  parameter int header_width_p = 128,
  parameter int data_width_p   = 64
);
  localparam int lg_num_req_lp = (num_req_p <= 2) ? 1 : $clog2(num_req_p);

  logic [num_req_p-1:0]                req_i;
  logic [num_req_p*header_width_p-1:0] req_header_i;
  logic [num_req_p*data_width_p-1:0]   req_data_i;
  logic [num_req_p-1:0]                req_v_i;
  logic [num_req_p-1:0]                req_ready_then_o;
  logic [num_req_p-1:0]                grant_o;
  logic [lg_num_req_lp-1:0]            grant_id_o;
  logic [header_width_p-1:0]           pump_header_o;
  logic [data_width_p-1:0]             pump_data_o;
  logic                                pump_v_o;
  logic                                pump_ready_then_i;
  logic                                pump_last_i;
  logic                                busy_o;

  modport slave (
    input  req_i, req_header_i, req_data_i, req_v_i, pump_ready_then_i, pump_last_i,
    output req_ready_then_o, grant_o, grant_id_o, pump_header_o, pump_data_o,
           pump_v_o, busy_o
  );

  modport master (
    output req_i, req_header_i, req_data_i, req_v_i, pump_ready_then_i, pump_last_i,
    input  req_ready_then_o, grant_o, grant_id_o, pump_header_o, pump_data_o,
           pump_v_o, busy_o
  );
endinterface

// File: rtl/bp_me_stream_pump_arb.sv
// Round-robin arbiter that locks one requester onto a shared stream pump port
// for a whole stream and hands over back-to-back on the last beat.
module bp_me_stream_pump_arb #(
  parameter int num_req_p      = 4,
  parameter int header_width_p = 128,
  parameter int data_width_p   = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bp_me_stream_pump_arb_if.slave  bus
);
  localparam int lg_num_req_lp = (num_req_p <= 2) ? 1 : $clog2(num_req_p);

  typedef enum logic {e_idle = 1'b0, e_grant = 1'b1} state_e;

  state_e                   state_r, state_n;
  logic [num_req_p-1:0]     grant_r, grant_n;
  logic [lg_num_req_lp-1:0] grant_id_r, grant_id_n;
  logic [lg_num_req_lp-1:0] rr_ptr_r, rr_ptr_n;

  logic                     any_req;
  logic                     beat_v;
  logic                     release_beat;
  logic [lg_num_req_lp-1:0] ptr_after;
  logic [lg_num_req_lp-1:0] pick_ptr;
  logic [lg_num_req_lp-1:0] win;

  // First requesting index at or after ptr, wrapping modulo num_req_p.
  function automatic logic [lg_num_req_lp-1:0] rr_pick(
    input logic [num_req_p-1:0]     req,
    input logic [lg_num_req_lp-1:0] ptr
  );
    logic [lg_num_req_lp-1:0] pick;
    int idx;
    pick = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (req[idx]) pick = lg_num_req_lp'(idx);
    end
    return pick;
  endfunction

  // Increment modulo num_req_p so unused codes are never produced.
  function automatic logic [lg_num_req_lp-1:0] next_ptr(input logic [lg_num_req_lp-1:0] id);
    if (id == lg_num_req_lp'(num_req_p - 1)) return '0;
    return id + lg_num_req_lp'(1);
  endfunction

  assign any_req      = |bus.req_i;
  assign beat_v       = |(bus.req_v_i & grant_r);
  assign release_beat = (state_r == e_grant) && beat_v && bus.pump_last_i;
  assign ptr_after    = next_ptr(grant_id_r);
  // A handover picks from the post-release pointer so the owner goes to the back.
  assign pick_ptr     = release_beat ? ptr_after : rr_ptr_r;
  assign win          = rr_pick(bus.req_i, pick_ptr);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_idle;
      grant_r    <= '0;
      grant_id_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      state_r    <= state_n;
      grant_r    <= grant_n;
      grant_id_r <= grant_id_n;
      rr_ptr_r   <= rr_ptr_n;
    end
  end

  always_comb begin
    state_n    = state_r;
    grant_n    = grant_r;
    grant_id_n = grant_id_r;
    rr_ptr_n   = rr_ptr_r;
    case (state_r)
      e_idle: begin
        if (any_req) begin
          state_n    = e_grant;
          grant_n    = num_req_p'(1) << win;
          grant_id_n = win;
        end
      end
      e_grant: begin
        // The lock ignores the owner's req_i; only the last accepted beat frees it.
        if (release_beat) begin
          rr_ptr_n = ptr_after;
          if (any_req) begin
            grant_n    = num_req_p'(1) << win;
            grant_id_n = win;
          end else begin
            state_n    = e_idle;
            grant_n    = '0;
            grant_id_n = '0;
          end
        end
      end
      default: begin
        state_n    = e_idle;
        grant_n    = '0;
        grant_id_n = '0;
      end
    endcase
  end

  always_comb begin
    bus.pump_header_o    = '0;
    bus.pump_data_o      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant_r[i]) begin
        bus.pump_header_o = bus.pump_header_o | bus.req_header_i[i*header_width_p +: header_width_p];
        bus.pump_data_o   = bus.pump_data_o | bus.req_data_i[i*data_width_p +: data_width_p];
      end
    end
    bus.req_ready_then_o = (state_r == e_grant) ? (grant_r & {num_req_p{bus.pump_ready_then_i}})
                                                : '0;
    bus.pump_v_o         = beat_v;
    bus.grant_o          = grant_r;
    bus.grant_id_o       = grant_id_r;
    bus.busy_o           = (state_r == e_grant);
  end
endmodule

// File: tb/tb_bp_me_stream_pump_arb.sv
// Directed bench for the stream pump arbiter: fairness, lock, masking,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_bp_me_stream_pump_arb;
  localparam int N = 4;
  localparam int H = 32;
  localparam int D = 16;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  bp_me_stream_pump_arb_if #(.num_req_p(N), .header_width_p(H), .data_width_p(D)) bus ();

  bp_me_stream_pump_arb #(.num_req_p(N), .header_width_p(H), .data_width_p(D)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [D-1:0] val);
    bus.req_data_i[idx*D +: D] = val;
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.req_i             = '0;
    bus.req_v_i           = '0;
    bus.req_data_i        = '0;
    bus.pump_ready_then_i = 1'b1;
    bus.pump_last_i       = 1'b0;
    for (int i = 0; i < N; i++) bus.req_header_i[i*H +: H] = 32'hA0A0_0000 + i;

    // Reset state
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_id", bus.grant_id_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ready", bus.req_ready_then_o, 0);
    chk("rst_v", bus.pump_v_o, 0);
    cyc();
    rst_n = 1'b1;

    // Fairness: all request, 2-beat streams, order 0,1,2,3,0 without bubbles
    bus.req_i = 4'b1111;
    @(negedge clk);
    chk("fair_lat", bus.grant_o, 0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      bus.req_v_i     = 4'(1 << o);
      bus.pump_last_i = 1'b0;
      set_data(o, 16'h0100 + 16'(k));
      @(negedge clk);
      chk($sformatf("fair%0d_grant_b1", k), bus.grant_o, 64'(1 << o));
      chk($sformatf("fair%0d_v_b1", k), bus.pump_v_o, 1);
      cyc();
      bus.pump_last_i = 1'b1;
      if (k == 4) bus.req_i = 4'b0000;
      @(negedge clk);
      chk($sformatf("fair%0d_grant_b2", k), bus.grant_o, 64'(1 << o));
      chk($sformatf("fair%0d_data", k), bus.pump_data_o, 16'h0100 + 16'(k));
      cyc();
    end
    bus.req_v_i     = '0;
    bus.pump_last_i = 1'b0;
    @(negedge clk);
    chk("fair_idle", bus.busy_o, 0);

    // Single request for requester 2, 4 beats
    cyc();
    bus.req_i = 4'b0100;
    @(negedge clk);
    chk("single_lat", bus.grant_o, 0);
    cyc();
    bus.req_i = 4'b0000;
    for (int b = 1; b <= 4; b++) begin
      bus.req_v_i     = 4'b0100;
      bus.pump_last_i = (b == 4);
      set_data(2, 16'(b));
      @(negedge clk);
      if (b == 1) begin
        chk("single_grant", bus.grant_o, 4'b0100);
        chk("single_id", bus.grant_id_o, 2);
        chk("single_busy", bus.busy_o, 1);
        chk("single_ready", bus.req_ready_then_o, 4'b0100);
        chk("single_hdr", bus.pump_header_o, 32'hA0A0_0002);
      end
      chk($sformatf("single_data_b%0d", b), bus.pump_data_o, 16'(b));
      cyc();
    end
    bus.req_v_i     = '0;
    bus.pump_last_i = 1'b0;
    @(negedge clk);
    chk("single_idle_busy", bus.busy_o, 0);
    chk("single_idle_grant", bus.grant_o, 0);
    chk("single_idle_hdr", bus.pump_header_o, 0);

    // Pointer now 3: requests 0,1,2 must wrap to 0; then single-beat release
    cyc();
    bus.req_i = 4'b0111;
    cyc();
    bus.req_i       = 4'b0000;
    bus.req_v_i     = 4'b0001;
    bus.pump_last_i = 1'b1;
    @(negedge clk);
    chk("wrap_grant", bus.grant_o, 4'b0001);
    chk("onebeat_v", bus.pump_v_o, 1);
    cyc();
    bus.req_v_i     = '0;
    bus.pump_last_i = 1'b0;
    @(negedge clk);
    chk("onebeat_idle", bus.busy_o, 0);

    // Lock: owner 1 drops req after beat 1, requester 3 waits
    cyc();
    bus.req_i = 4'b1010;
    cyc();
    for (int b = 1; b <= 4; b++) begin
      if (b == 1) bus.req_i = 4'b1000;
      bus.req_v_i     = 4'b0010;
      bus.pump_last_i = (b == 4);
      @(negedge clk);
      chk($sformatf("lock_b%0d", b), bus.grant_o, 4'b0010);
      cyc();
    end
    bus.req_i       = 4'b0000;
    bus.req_v_i     = 4'b1000;
    bus.pump_last_i = 1'b0;
    @(negedge clk);
    chk("lock_next", bus.grant_o, 4'b1000);
    chk("lock_next_id", bus.grant_id_o, 3);

    // Reset during beat 2 of owner 3: outputs clear before any clock edge
    cyc();
    bus.req_v_i = 4'b1000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", bus.grant_o, 0);
    chk("arst_id", bus.grant_id_o, 0);
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_ready", bus.req_ready_then_o, 0);
    chk("arst_v", bus.pump_v_o, 0);
    cyc();
    rst_n       = 1'b1;
    bus.req_v_i = '0;
    bus.req_i   = 4'b1000;
    @(negedge clk);
    chk("arst_lat", bus.grant_o, 0);
    cyc();
    bus.req_i       = 4'b0000;
    bus.req_v_i     = 4'b1000;
    bus.pump_last_i = 1'b1;
    @(negedge clk);
    chk("arst_regrant", bus.grant_o, 4'b1000);
    cyc();
    bus.req_v_i     = '0;
    bus.pump_last_i = 1'b0;

    // Masking and backpressure on owner 2 with requester 0 driving v
    bus.req_i = 4'b0100;
    cyc();
    bus.req_i   = 4'b0000;
    bus.req_v_i = 4'b0101;
    set_data(0, 16'hFFFF);
    set_data(2, 16'h0021);
    @(negedge clk);
    chk("mask_v", bus.pump_v_o, 1);
    chk("mask_data", bus.pump_data_o, 16'h0021);
    chk("mask_ready", bus.req_ready_then_o, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      cyc();
      bus.pump_ready_then_i = 1'b0;
      bus.req_v_i           = 4'b0001;
      @(negedge clk);
      chk($sformatf("bp%0d_ready", c), bus.req_ready_then_o, 0);
      chk($sformatf("bp%0d_v", c), bus.pump_v_o, 0);
      chk($sformatf("bp%0d_grant", c), bus.grant_o, 4'b0100);
    end
    cyc();
    bus.pump_ready_then_i = 1'b1;
    bus.req_v_i           = 4'b0101;
    set_data(2, 16'h0022);
    @(negedge clk);
    chk("bp_b2_v", bus.pump_v_o, 1);
    chk("bp_b2_data", bus.pump_data_o, 16'h0022);
    cyc();
    set_data(2, 16'h0023);
    bus.pump_last_i = 1'b1;
    @(negedge clk);
    chk("bp_b3_data", bus.pump_data_o, 16'h0023);
    chk("bp_b3_grant", bus.grant_o, 4'b0100);
    cyc();
    bus.req_v_i     = '0;
    bus.pump_last_i = 1'b0;
    @(negedge clk);
    chk("bp_idle", bus.busy_o, 0);

    // Pointer is 3 here; after reset it must restart at 0 so 2 beats 3
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n     = 1'b1;
    bus.req_i = 4'b1100;
    cyc();
    @(negedge clk);
    chk("ptr_rst_grant", bus.grant_o, 4'b0100);
    chk("ptr_rst_id", bus.grant_id_o, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bp_me_stream_pump_arb.md
BP_ME_STREAM_PUMP_ARB -- requirements
Module: bp_me_stream_pump_arb

Interface
REQ-001 Parameter num_req_p, default 4, number of requesters sharing one stream pump output FSM port (range 2..16).
REQ-002 Parameter header_width_p, default 128, width of the BedRock header presented by each requester.
REQ-003 Parameter data_width_p, default 64, width of one FSM data beat.
REQ-004 Parameter lg_num_req_lp, derived, equal to max(1, ceil(log2(num_req_p))).
REQ-005 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 clk_i  input  1  sole clock, all state on rising edge.
REQ-007 reset_n_i  input  1  asynchronous active-low reset.
REQ-008 req_i  input  num_req_p  per-requester stream request, level held until granted.
REQ-009 req_header_i  input  num_req_p*header_width_p  per-requester header, slice i belongs to requester i.
REQ-010 req_data_i  input  num_req_p*data_width_p  per-requester beat data.
REQ-011 req_v_i  input  num_req_p  per-requester beat valid, ready-then protocol.
REQ-012 req_ready_then_o  output  num_req_p  per-requester ready, asserted before v may be raised.
REQ-013 grant_o  output  num_req_p  registered one-hot grant, all-zero when idle.
REQ-014 grant_id_o  output  lg_num_req_lp  binary index of the current owner, 0 when idle.
REQ-015 pump_header_o  output  header_width_p  owner header to pump out_fsm_header_i.
REQ-016 pump_data_o  output  data_width_p  owner data to pump out_fsm_data_i.
REQ-017 pump_v_o  output  1  beat valid to pump out_fsm_v_i.
REQ-018 pump_ready_then_i  input  1  pump out_fsm_ready_then_o.
REQ-019 pump_last_i  input  1  pump out_fsm_last_o, last beat of the current stream.
REQ-020 busy_o  output  1  high while in state e_grant.

Function
REQ-021 FSM SHALL have exactly two states, e_idle and e_grant; reset state is e_idle.
REQ-022 In e_idle with req_i nonzero, the block SHALL select a winner round-robin, starting at index rr_ptr and wrapping modulo num_req_p, then enter e_grant next cycle with grant_o one-hot on the winner (1-cycle req-to-grant latency).
REQ-023 In e_idle with req_i zero, state, grant_o and rr_ptr SHALL hold.
REQ-024 In e_grant, req_ready_then_o SHALL equal grant_o ANDed bitwise with pump_ready_then_i; in e_idle it SHALL be all-zero.
REQ-025 pump_v_o SHALL be the OR of (req_v_i & grant_o); a v from a non-owner SHALL be masked and have no effect.
REQ-026 pump_header_o and pump_data_o SHALL be the owner slices, combinational mux on the registered grant; they SHALL be zero in e_idle.
REQ-027 Grant SHALL be locked until a beat with pump_v_o and pump_last_i both high; deassertion of the owner's req_i mid-stream SHALL NOT release the lock.
REQ-028 On the releasing beat, rr_ptr SHALL become (owner+1) mod num_req_p.
REQ-029 On the releasing beat, if req_i is nonzero, the block SHALL remain in e_grant and grant the next round-robin winner from the updated rr_ptr next cycle, with no idle bubble; otherwise it SHALL enter e_idle.
REQ-030 A new request arriving in the same cycle as the releasing beat SHALL be eligible for the back-to-back grant.
REQ-031 Single-beat streams (pump_last_i high on the first beat) SHALL release on that beat.
REQ-032 If num_req_p is not a power of two, unused pointer codes SHALL never occur.

Reset
REQ-033 Asserting reset_n_i low SHALL asynchronously force state e_idle, grant_o=0, grant_id_o=0, rr_ptr=0, busy_o=0, req_ready_then_o=0 and pump_v_o=0, including mid-stream; the in-flight stream is abandoned.
REQ-034 Reset deassertion SHALL be sampled synchronously; the first grant may occur one cycle after reset release.

Verification
REQ-035 Single request: req_i=4'b0100 at cycle 0 -> grant_o=4'b0100, grant_id_o=2, busy_o=1 at cycle 1; 4-beat stream with last on beat 4 -> idle next cycle, rr_ptr=3.
REQ-036 Fairness: req_i=4'b1111 held, every stream 2 beats -> grant order 0,1,2,3,0 with back-to-back grants and no idle cycle between streams.
REQ-037 Lock: owner 1 drops req_i after beat 1 of 4 while req_i[3]=1 -> grant stays 4'b0010 until beat 4 last, then 4'b1000 next cycle.
REQ-038 Masking: non-owner 0 drives req_v_i=1 during owner 2 stream -> pump_v_o follows only req_v_i[2]; pump_data_o equals slice 2.
REQ-039 Backpressure: pump_ready_then_i=0 for 3 cycles mid-stream -> req_ready_then_o=0 for those cycles, grant held, no beat lost.
REQ-040 Reset mid-stream: reset_n_i low during beat 2 of owner 3 -> outputs zero immediately, without waiting for a clock edge; after release, req_i=4'b1000 is granted with rr_ptr restarted at 0.
